// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock-enable generator.
// Default divisors are the rates used by the synth datapath consumers.
package clkdiv_pkg;

   localparam int unsigned DIV_MOD       = 1;
   localparam int unsigned DIV_MULT      = 32;
   localparam int unsigned DIV_SAMPLE_X2 = 256;
   localparam int unsigned DIV_SAMPLE    = 512;
   localparam int unsigned DIV_ADSR      = 262144;

   // Channel-select width; never below one bit so a single-channel build still has a port.
   function automatic int unsigned ch_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: registered tick every active_q advances, lvl toggles per tick.
// Tick appears the cycle after the wrapping edge; no backpressure, adv_i gates progress.
module clkdiv_chan #(
   parameter int unsigned      CNT_W   = 20,
   parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
   input  logic             clk_i,
   input  logic             arstn_i,
   input  logic             adv_i,
   input  logic             sync_i,
   input  logic             wr_i,
   input  logic [CNT_W-1:0] wdata_i,
   output logic             tick_o,
   output logic             lvl_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0] active_q, active_d;
   logic             tick_q, tick_d;
   logic             lvl_q, lvl_d;

   always_comb begin
      shadow_d = wr_i ? wdata_i : shadow_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      lvl_d    = lvl_q;
      tick_d   = 1'b0;
      if (sync_i) begin
         cnt_d    = '0;
         lvl_d    = 1'b0;
         active_d = shadow_d;
      end else if (adv_i && (active_q != '0)) begin
         // New divisor only lands at a wrap, so periods are never truncated or stretched.
         if (cnt_q == active_q - CNT_W'(1)) begin
            cnt_d    = '0;
            tick_d   = 1'b1;
            lvl_d    = ~lvl_q;
            active_d = shadow_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         cnt_q    <= '0;
         shadow_q <= DIV_RST;
         active_q <= DIV_RST;
         tick_q   <= 1'b0;
         lvl_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         tick_q   <= tick_d;
         lvl_q    <= lvl_d;
      end
   end

   assign tick_o = tick_q;
   assign lvl_o  = lvl_q;

endmodule

// File: rtl/clkdiv_gen.sv
// NCH programmable clock-enable channels with shadowed divisors and optional cascading.
// Ticks are registered (one cycle after the wrapping edge, +1 per cascade stage); no backpressure.
module clkdiv_gen import clkdiv_pkg::*; #(
   parameter int unsigned          NCH     = 4,
   parameter int unsigned          CNT_W   = 20,
   parameter logic [NCH*CNT_W-1:0] DIV_RST = {NCH{CNT_W'(1)}},
   parameter logic [NCH-1:0]       EN_RST  = {NCH{1'b1}},
   parameter logic [NCH-1:0]       CASC    = {NCH{1'b0}}
) (
   input  logic                   clk,
   input  logic                   arstn,
   input  logic                   cfg_we,
   input  logic [ch_w(NCH)-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]       cfg_div,
   input  logic [NCH-1:0]         cfg_en,
   input  logic                   sync,
   output logic [NCH-1:0]         tick,
   output logic [NCH-1:0]         lvl
);

   localparam int unsigned CH_W = ch_w(NCH);

   logic [NCH-1:0] en_q;
   logic [NCH-1:0] adv;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) en_q <= EN_RST;
      else        en_q <= cfg_en;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic wr;

      // Selects beyond NCH-1 match no channel, so such writes fall away.
      assign wr = cfg_we && (cfg_ch == CH_W'(i));

      if (i == 0 || !CASC[i]) begin : g_free
         assign adv[i] = en_q[i];
      end else begin : g_casc
         assign adv[i] = en_q[i] & tick[i-1];
      end

      clkdiv_chan #(
         .CNT_W   (CNT_W),
         .DIV_RST (DIV_RST[i*CNT_W +: CNT_W])
      ) u_chan (
         .clk_i   (clk),
         .arstn_i (arstn),
         .adv_i   (adv[i]),
         .sync_i  (sync),
         .wr_i    (wr),
         .wdata_i (cfg_div),
         .tick_o  (tick[i]),
         .lvl_o   (lvl[i])
      );
   end

endmodule

// File: tb/tb_clkdiv_gen.sv
// Bench for clkdiv_gen: reset-timing vector table plus queued tick-edge expectations.
module tb_clkdiv_gen;

   logic        clk = 1'b0;
   logic        arstn = 1'b0;
   logic        cfg_we, sync;
   logic [1:0]  cfg_ch;
   logic [19:0] cfg_div;
   logic [3:0]  cfg_en;
   logic [3:0]  tick, lvl;

   logic        cfg_we_c, sync_c;
   logic [1:0]  cfg_ch_c;
   logic [19:0] cfg_div_c;
   logic [3:0]  cfg_en_c;
   logic [3:0]  tick_c, lvl_c;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int exp_q[$];

   typedef struct {
      int   edge_n;
      int   ch;
      logic t;
      logic l;
   } vec_t;
   vec_t vt[$];

   always #5 clk = ~clk;

   clkdiv_gen #(
      .NCH(4), .CNT_W(20),
      .DIV_RST({20'd5, 20'd3, 20'd4, 20'd1}),
      .EN_RST(4'b1111), .CASC(4'b0000)
   ) dut (
      .clk(clk), .arstn(arstn), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
      .cfg_en(cfg_en), .sync(sync), .tick(tick), .lvl(lvl)
   );

   clkdiv_gen #(
      .NCH(4), .CNT_W(20),
      .DIV_RST({20'd1, 20'd1, 20'd4, 20'd3}),
      .EN_RST(4'b1111), .CASC(4'b0010)
   ) dut_c (
      .clk(clk), .arstn(arstn), .cfg_we(cfg_we_c), .cfg_ch(cfg_ch_c), .cfg_div(cfg_div_c),
      .cfg_en(cfg_en_c), .sync(sync_c), .tick(tick_c), .lvl(lvl_c)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      arstn   = 1'b0;
      cfg_we  = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_en = 4'hF; sync = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      arstn = 1'b1;
      cyc   = 0;
   endtask

   // Steps until until_c, matching every tick of the watched channel against exp_q.
   task automatic watch(input string name, input bit sel, input int ch, input int until_c, input bit last);
      logic t, prev0;
      int   e;
      while (cyc < until_c) begin
         prev0 = tick_c[0];
         step();
         t = sel ? tick_c[ch] : tick[ch];
         if (t) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s: tick at edge %0d, none required", name, cyc);
            end else begin
               e = exp_q.pop_front();
               if (e != cyc) begin
                  errors++;
                  $display("FAIL %s: tick at edge %0d, required at edge %0d", name, cyc, e);
               end
            end
            if (sel && ch == 1) begin
               checks++;
               if (!prev0) begin
                  errors++;
                  $display("FAIL %s_lag: upstream tick before edge %0d was 0, required 1", name, cyc);
               end
            end
         end
      end
      if (last) begin
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d required ticks missing, next at edge %0d", name, exp_q.size(), exp_q[0]);
            exp_q.delete();
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      cfg_we_c = 1'b0; cfg_ch_c = '0; cfg_div_c = '0; cfg_en_c = 4'hF; sync_c = 1'b0;

      // Reset timing with DIV_RST = {ch0:1, ch1:4, ch2:3, ch3:5}: {edge, ch, tick, lvl}
      vt.push_back('{1, 0, 1'b1, 1'b1});
      vt.push_back('{1, 1, 1'b0, 1'b0});
      vt.push_back('{2, 0, 1'b1, 1'b0});
      vt.push_back('{3, 1, 1'b0, 1'b0});
      vt.push_back('{3, 2, 1'b1, 1'b1});
      vt.push_back('{4, 1, 1'b1, 1'b1});
      vt.push_back('{4, 3, 1'b0, 1'b0});
      vt.push_back('{5, 1, 1'b0, 1'b1});
      vt.push_back('{5, 3, 1'b1, 1'b1});
      vt.push_back('{6, 2, 1'b1, 1'b0});
      vt.push_back('{7, 0, 1'b1, 1'b1});
      vt.push_back('{8, 1, 1'b1, 1'b0});
      vt.push_back('{8, 0, 1'b1, 1'b0});
      vt.push_back('{9, 1, 1'b0, 1'b0});
      vt.push_back('{10, 3, 1'b1, 1'b0});
      vt.push_back('{11, 3, 1'b0, 1'b0});
      vt.push_back('{12, 1, 1'b1, 1'b1});
      vt.push_back('{12, 2, 1'b1, 1'b0});

      do_reset();
      chk("reset_tick", 32'(tick), 32'd0);
      chk("reset_lvl", 32'(lvl), 32'd0);
      foreach (vt[k]) begin
         while (cyc < vt[k].edge_n) step();
         chk($sformatf("vec%0d_tick_ch%0d_e%0d", k, vt[k].ch, vt[k].edge_n), 32'(tick[vt[k].ch]), 32'(vt[k].t));
         chk($sformatf("vec%0d_lvl_ch%0d_e%0d", k, vt[k].ch, vt[k].edge_n), 32'(lvl[vt[k].ch]), 32'(vt[k].l));
      end

      // Mid-count shadow write on ch1: current period completes at 4, then 6-cycle periods.
      do_reset();
      step();
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 20'd6;
      step();
      cfg_we = 1'b0;
      exp_q = '{4, 10, 16};
      watch("shadow_ch1", 1'b0, 1, 20, 1'b1);

      // Cascade: ch1 counts ch0 ticks (3 x 4 = 12), one cycle behind its upstream tick.
      do_reset();
      exp_q = '{13, 25};
      watch("casc_ch1", 1'b1, 1, 30, 1'b1);

      // ch2 enable dropped for 7 cycles with cnt=2 pending.
      do_reset();
      exp_q = '{10, 13, 16};
      watch("hold_ch2", 1'b0, 2, 1, 1'b0);
      cfg_en[2] = 1'b0;
      watch("hold_ch2", 1'b0, 2, 8, 1'b0);
      chk("hold_lvl2", 32'(lvl[2]), 32'd0);
      cfg_en[2] = 1'b1;
      watch("hold_ch2", 1'b0, 2, 17, 1'b1);
      chk("resume_lvl2", 32'(lvl[2]), 32'd1);

      // div=0 on ch3 via sync halts it; then div=2 written together with sync.
      do_reset();
      step();
      cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 20'd0;
      step();
      cfg_we = 1'b0; sync = 1'b1;
      step();
      sync = 1'b0;
      chk("halt_lvl3_after_sync", 32'(lvl[3]), 32'd0);
      exp_q.delete();
      watch("halt_ch3", 1'b0, 3, 25, 1'b1);
      chk("halt_lvl3_held", 32'(lvl[3]), 32'd0);
      cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 20'd2; sync = 1'b1;
      step();
      cfg_we = 1'b0; sync = 1'b0;
      exp_q = '{28, 30};
      watch("syncwr_ch3", 1'b0, 3, 31, 1'b1);

      // Async reset mid-count after a pending ch1 rewrite; divisors must revert.
      do_reset();
      step();
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 20'd7;
      step();
      cfg_we = 1'b0;
      while (cyc < 6) step();
      chk("pre_arst_tick", 32'(tick), 32'h5);
      chk("pre_arst_lvl", 32'(lvl), 32'hA);
      #2;
      arstn = 1'b0;
      #1;
      chk("arst_tick", 32'(tick), 32'd0);
      chk("arst_lvl", 32'(lvl), 32'd0);
      do_reset();
      exp_q = '{4, 8};
      watch("post_arst_ch1", 1'b0, 1, 9, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clkdiv_gen.md
Name: clkdiv_gen

Overview:
- Synchronous, programmable clock-enable generator; parametrised successor to the fixed ripple-TFF divider.
- All logic runs on the single system clock. Each of NCH channels emits a one-cycle tick strobe plus a 50%-duty level output.
- Downstream blocks (modulator, sample, ADSR, multiplier pipelines) use ticks as clock enables instead of derived clocks.
- Divisors are runtime-programmable, glitch-free on update. Channels can be cascaded so a channel counts the ticks of its predecessor.

Parameters:
- NCH, 4, number of divider channels (1..8)
- CNT_W, 20, counter/divisor width in bits
- DIV_RST, {NCH{20'd1}}, flattened NCH*CNT_W reset divisors; channel i at bits [i*CNT_W +: CNT_W]
- EN_RST, {NCH{1'b1}}, per-channel enable reset value
- CASC, {NCH{1'b0}}, bit i=1: channel i advances on tick[i-1] instead of every clk; bit 0 ignored

Ports:
- clk  in  1  system clock
- arstn  in  1  asynchronous active-low reset
- cfg_we  in  1  write strobe for divisor shadow register
- cfg_ch  in  clog2(NCH) (min 1)  channel select for write
- cfg_div  in  CNT_W  divisor value
- cfg_en  in  NCH  per-channel run enable, level-sampled every cycle
- sync  in  1  restart: zero all counters, load shadows into active
- tick  out  NCH  one-cycle enable strobe per channel
- lvl  out  NCH  square wave, toggles on each tick (period 2*div)

Behaviour:
- Reset (async assert, sync-to-clk release by the top level):
  - shadow_i = active_i = DIV_RST slice
  - cnt_i = 0, tick = 0, lvl = 0
  - enable register = EN_RST until first clk edge, then follows cfg_en
- Advance condition adv_i:
  - en_i & (CASC[i] && i>0 ? tick[i-1] : 1)
- Per-channel counter, on each clk edge when adv_i and active_i != 0:
  - if cnt_i == active_i-1: cnt_i <= 0, tick_i <= 1, lvl_i <= ~lvl_i, active_i <= shadow_i
  - else: cnt_i <= cnt_i+1, tick_i <= 0
- When not advancing, tick_i <= 0 and cnt_i/lvl_i hold; disable mid-count holds the phase.
- Timing: tick_i is registered. With div=N, non-cascaded, enabled from reset: tick high in the cycle after edges N, 2N, 3N...; exact period N cycles.
- div=1: tick_i constantly 1 while enabled; lvl toggles every cycle.
- div=0: channel halted; tick_i=0, cnt_i and lvl_i hold. A later shadow write only takes effect via sync, because no wrap occurs.
- Write cfg_we: shadow[cfg_ch] <= cfg_div. Active value updates only at the next wrap of that channel, so no truncated or stretched periods. cfg_ch >= NCH: write ignored.
- sync (synchronous, highest priority):
  - cnt = 0, tick = 0, lvl = 0, active = shadow for all channels
  - If cfg_we in the same cycle, the written value lands in both shadow and active of that channel.
- Cascade: the downstream period equals the product of divisors. The downstream tick lags the upstream tick that caused it by 1 cycle per stage.
- Counter width: cnt_i never exceeds active_i-1. A shadow load that lowers the divisor happens at a wrap (cnt=0), so no overflow path exists.

Decomposition:
- Shared header/package clkdiv_pkg:
  - CH_W = clog2(NCH) helper function
  - default divisor constants: DIV_MOD=1, DIV_MULT=32, DIV_SAMPLE_X2=256, DIV_SAMPLE=512, DIV_ADSR=262144
- Sub-module clkdiv_chan: one channel (cnt, shadow, active, tick, lvl). Inputs: adv, sync, wr, wdata.
- Top clkdiv_gen: write decode, cascade muxing of adv, generate loop over NCH.

Test Plan:
- Reset, DIV_RST={1,4,3,5}, all enabled: ch1 tick high after edges 4,8,12; ch3 period 5; ch0 tick steady 1; lvl1 period 8 cycles.
- Write ch1 div=6 at cycle 2 (mid-count), ch1 at 4: next tick still at edge 4, then edges 10,16; no short period.
- CASC=4'b0010, ch0 div=3, ch1 div=4: ch1 tick period 12 cycles, each ch1 tick 1 cycle after a ch0 tick.
- cfg_en[2] low for 7 cycles mid-count: ch2 holds cnt and lvl, resumes with remaining count; no tick while low.
- Write div=0 to ch3 then sync: ch3 tick stays 0 indefinitely. Write 2 with sync in same cycle: ticks after edges +2,+4.
- arstn asserted mid-count: all tick/lvl go 0 immediately (async); after release, divisors return to DIV_RST and the first tick matches the scenario-1 timing.
